// File: rtl/sobel_window_core.sv
// sobel_window_core: 3x3 Sobel gradient magnitude over line-buffer column taps.
// Stage 0 shifts columns into the window and tracks position in the frame,
// stage 1 computes signed Gx/Gy, stage 2 forms |Gx|+|Gy| and saturates.
// Optional macro SOBEL_THRESHOLD_EN adds thresh_i and turns the output into a
// binary edge map (255 where the magnitude reaches the threshold, else 0).
module sobel_window_core #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 478
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [7:0] data0_i,
    input  logic [7:0] data1_i,
    input  logic [7:0] data2_i,
`ifdef SOBEL_THRESHOLD_EN
    input  logic [7:0] thresh_i,
`endif
    output logic       valid_o,
    output logic [7:0] pixel_o,
    output logic       done_o
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    // win[r][c]: row 0 is the top (oldest) line, column 2 is the newest column
    logic [2:0][2:0][7:0] win;
    logic [2:0][7:0]      taps;
    logic [CW-1:0]        col_cnt;
    logic [RW-1:0]        row_cnt;
    logic                 wv;
    logic                 d0;

    logic [10:0]          gx_c;
    logic [10:0]          gy_c;
    logic signed [10:0]   gx;
    logic signed [10:0]   gy;
    logic                 v1;
    logic                 d1;

    logic [10:0]          abs_x;
    logic [10:0]          abs_y;
    logic [11:0]          mag;
    logic [7:0]           result;

    assign taps = {data2_i, data1_i, data0_i};

    // Stage 0: shift the window on accepted columns and mark complete windows
    always_ff @(posedge clk) begin
        if (rst) begin
            win     <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            wv      <= 1'b0;
            d0      <= 1'b0;
        end else begin
            wv <= 1'b0;
            d0 <= 1'b0;
            if (valid_i) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                    win[r][2] <= taps[r];
                end
                wv <= (col_cnt >= CW'(2));
                d0 <= (col_cnt == CW'(IMG_WIDTH - 1)) && (row_cnt == RW'(IMG_HEIGHT - 1));
                if (col_cnt == CW'(IMG_WIDTH - 1)) begin
                    col_cnt <= '0;
                    if (row_cnt == RW'(IMG_HEIGHT - 1)) begin
                        row_cnt <= '0;
                    end else begin
                        row_cnt <= row_cnt + RW'(1);
                    end
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
            end
        end
    end

    // Kernel sums; the difference of two non-negative sums <= 1020 fits 11-bit two's complement
    always_comb begin
        gx_c = ({3'b0, win[0][2]} + {2'b0, win[1][2], 1'b0} + {3'b0, win[2][2]})
             - ({3'b0, win[0][0]} + {2'b0, win[1][0], 1'b0} + {3'b0, win[2][0]});
        gy_c = ({3'b0, win[2][0]} + {2'b0, win[2][1], 1'b0} + {3'b0, win[2][2]})
             - ({3'b0, win[0][0]} + {2'b0, win[0][1], 1'b0} + {3'b0, win[0][2]});
    end

    // Stage 1: register the gradients every cycle alongside the window-valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            gx <= '0;
            gy <= '0;
            v1 <= 1'b0;
            d1 <= 1'b0;
        end else begin
            gx <= $signed(gx_c);
            gy <= $signed(gy_c);
            v1 <= wv;
            d1 <= d0;
        end
    end

    // Magnitude and output mapping (saturation, or threshold when enabled)
    always_comb begin
        abs_x = gx[10] ? 11'(-gx) : 11'(gx);
        abs_y = gy[10] ? 11'(-gy) : 11'(gy);
        mag   = {1'b0, abs_x} + {1'b0, abs_y};
`ifdef SOBEL_THRESHOLD_EN
        result = (mag >= {4'b0, thresh_i}) ? 8'd255 : 8'd0;
`else
        result = (mag > 12'd255) ? 8'd255 : mag[7:0];
`endif
    end

    // Stage 2: present the pixel; pixel_o holds between valid outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            pixel_o <= '0;
            done_o  <= 1'b0;
        end else begin
            valid_o <= v1;
            done_o  <= d1;
            if (v1) begin
                pixel_o <= result;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_core.sv
// tb_sobel_window_core: directed vectors with a scoreboard for sobel_window_core
// (IMG_WIDTH=5, IMG_HEIGHT=3). Build with SOBEL_THRESHOLD_EN to exercise thresh_i.
module tb_sobel_window_core;

    typedef struct {
        logic [7:0] pix;
        logic       done;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_i = 1'b0;
    logic [7:0] data0_i = '0;
    logic [7:0] data1_i = '0;
    logic [7:0] data2_i = '0;
    logic [7:0] thresh = 8'd128;
    logic       valid_o;
    logic [7:0] pixel_o;
    logic       done_o;

    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    exp_t sb[$];

    sobel_window_core #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .data0_i (data0_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
`ifdef SOBEL_THRESHOLD_EN
        .thresh_i(thresh),
`endif
        .valid_o (valid_o),
        .pixel_o (pixel_o),
        .done_o  (done_o)
    );

    // Free-running clock and cycle counter used for latency checks
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Map a hand-computed magnitude to the pixel the current build should show
    function automatic logic [7:0] exp_pix(input int mag);
`ifdef SOBEL_THRESHOLD_EN
        return (mag >= int'(thresh)) ? 8'd255 : 8'd0;
`else
        return (mag > 255) ? 8'd255 : 8'(mag);
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one column; an expected output is due 2 edges after the accepting edge
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                 input bit exp_out, input int mag, input bit exp_done);
        exp_t e;
        @(negedge clk);
        valid_i = 1'b1;
        data0_i = a;
        data1_i = b;
        data2_i = c;
        if (exp_out) begin
            e.pix  = exp_pix(mag);
            e.done = exp_done;
            e.cyc  = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
    endtask

    // One-cycle reset with valid_i deliberately high, which must be ignored
    task automatic doReset();
        @(negedge clk);
        rst     = 1'b1;
        valid_i = 1'b1;
        data0_i = 8'hAA;
        data1_i = 8'h55;
        data2_i = 8'hFF;
        @(negedge clk);
        rst     = 1'b0;
        valid_i = 1'b0;
    endtask

    // Ramp line 0,10,20,30,40 on all taps: every complete window gives Gx=80, Gy=0
    task automatic sendRamp(input bit outs, input bit last_row);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(8'(c * 10), 8'(c * 10), 8'(c * 10), outs && (c >= 2), 80,
                          last_row && (c == 4));
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a pixel
    always @(negedge clk) begin
        exp_t e;
        if (valid_o) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("pixel", int'(pixel_o), int'(e.pix));
                checkOutput("done", int'(done_o), int'(e.done));
                checkOutput("latency_cycle", cyc, e.cyc);
            end
        end else if (done_o) begin
            checkOutput("done_without_valid", 1, 0);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_valid_o", int'(valid_o), 0);
        checkOutput("reset_pixel_o", int'(pixel_o), 0);
        checkOutput("reset_done_o", int'(done_o), 0);

        // Flat field: 15 columns of 100, zero gradient, done with the 9th output
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 5; c++) begin
                applyStimulus(8'd100, 8'd100, 8'd100, c >= 2, 0, (r == 2) && (c == 4));
            end
        end
        idle(4);

        // Horizontal ramp over a whole frame, back to back
        doReset();
        sendRamp(1'b1, 1'b0);
        sendRamp(1'b1, 1'b0);
        sendRamp(1'b1, 1'b1);
        idle(4);

        // Vertical step: only the bottom row is 50, Gy = 50+100+50 = 200
        doReset();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(8'd0, 8'd0, 8'd50, c >= 2, 200, 1'b0);
        end
        idle(4);

        // Saturation: windows (0,0,0), (0,0,255), (0,255,255) give 0, 1020, 1020
        doReset();
        applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b0);
        applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b0);
        applyStimulus(8'd0, 8'd0, 8'd0, 1'b1, 0, 1'b0);
        applyStimulus(8'd255, 8'd255, 8'd255, 1'b1, 1020, 1'b0);
        applyStimulus(8'd255, 8'd255, 8'd255, 1'b1, 1020, 1'b0);
        idle(4);

        // Stall: three idle cycles after the 2nd column leave values and count intact
        doReset();
        applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b0);
        applyStimulus(8'd10, 8'd10, 8'd10, 1'b0, 0, 1'b0);
        idle(3);
        applyStimulus(8'd20, 8'd20, 8'd20, 1'b1, 80, 1'b0);
        applyStimulus(8'd30, 8'd30, 8'd30, 1'b1, 80, 1'b0);
        idle(2);
        applyStimulus(8'd40, 8'd40, 8'd40, 1'b1, 80, 1'b0);
        idle(4);

        // Reset mid-row: row 1 outputs for columns 2 and 3 are still in flight and dropped
        doReset();
        sendRamp(1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(8'(c * 10), 8'(c * 10), 8'(c * 10), 1'b0, 0, 1'b0);
        end
        doReset();
        idle(2);
        sendRamp(1'b1, 1'b0);
        sendRamp(1'b1, 1'b0);
        sendRamp(1'b1, 1'b1);
        idle(6);

        // Bounded drain: every expected pixel must have been observed
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
